// File: rtl/vec_vsetvl_unit_pkg.sv
// Shared vector-CSR definitions: vtype field encodings, vset decode constants
// and the vsetvl unit state encoding.
package vec_vsetvl_unit_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'd0,
        LMUL_2    = 3'd1,
        LMUL_4    = 3'd2,
        LMUL_8    = 3'd3,
        LMUL_RSVD = 3'd4,
        LMUL_F8   = 3'd5,
        LMUL_F4   = 3'd6,
        LMUL_F2   = 3'd7
    } vlmul_e;

    typedef enum logic [2:0] {
        EW_8  = 3'd0,
        EW_16 = 3'd1,
        EW_32 = 3'd2,
        EW_64 = 3'd3
    } vew_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } vsetvl_state_e;

    localparam logic [6:0] VSET_OPCODE     = 7'h57;
    localparam logic [2:0] VSET_FUNCT3     = 3'b111;
    localparam logic [6:0] VSETVL_FUNCT7   = 7'b1000000;
    localparam int         VTYPE_VLMUL_LSB = 0;
    localparam int         VTYPE_VSEW_LSB  = 3;
    localparam int         VTYPE_VTA_BIT   = 6;
    localparam int         VTYPE_VMA_BIT   = 7;
    localparam int         VTYPE_FIELD_W   = 8;

    // VLMAX never exceeds VLEN (e8, m8), and is kept at least 11 bits wide.
    function automatic int vlmax_width(input int vlen);
        return ($clog2(vlen) + 1 > 11) ? $clog2(vlen) + 1 : 11;
    endfunction

endpackage

// File: rtl/vec_vsetvl_unit_vlmax_calc.sv
// Combinational VLMAX = (VLEN/SEW)*LMUL and vtype field legality check.
// Standalone so the CSR file can reuse it.
module vec_vlmax_calc
    import vec_vsetvl_unit_pkg::*;
#(
    parameter int VLEN    = 512,
    parameter int VLMAX_W = 11
) (
    input  vew_e               vsew,
    input  vlmul_e             vlmul,
    output logic [VLMAX_W-1:0] vlmax,
    output logic               vtype_legal
);

    logic [2:0]         sew_bits;
    logic [2:0]         lmul_bits;
    logic [VLMAX_W-1:0] elems_m1;

    assign sew_bits    = vsew;
    assign lmul_bits   = vlmul;
    // Fractional and reserved LMUL, and SEW above 64, are not supported.
    assign vtype_legal = !sew_bits[2] && !lmul_bits[2];
    assign elems_m1    = VLMAX_W'(VLEN) >> ({1'b0, sew_bits} + 4'd3);
    assign vlmax       = vtype_legal ? (elems_m1 << lmul_bits[1:0]) : '0;

endmodule

// File: rtl/vec_vsetvl_unit.sv
// vsetvli/vsetivli/vsetvl execution unit driving the vl/vtype CSR write port.
// Optional macro VSETVL_AVL_SPLIT_EN: AVL in (VLMAX, 2*VLMAX) yields vl=ceil(AVL/2).
module vec_vsetvl_unit
    import vec_vsetvl_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] cur_vl,
    input  logic            req_valid,
    output logic            req_ready,
    output logic [XLEN-1:0] vl_out,
    output logic [XLEN-1:0] vtype_out,
    output logic            csrwr_en,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            illegal,
    output logic            busy
);

    localparam int VLMAX_W = vlmax_width(VLEN);

    vsetvl_state_e      state;
    logic [XLEN-1:0]    inst_q, rs1_q, rs2_q, cur_vl_q;
    logic [4:0]         rs1_idx, rd_idx;
    logic               is_vset, is_vsetvli, is_vsetivli, is_vsetvl;
    logic               dec_illegal, vill, vtype_legal;
    logic [XLEN-1:0]    vtype_raw, avl, vlmax_x, vl_calc;
    logic [VLMAX_W-1:0] vlmax;

    assign rs1_idx     = inst_q[19:15];
    assign rd_idx      = inst_q[11:7];
    assign is_vset     = (inst_q[6:0] == VSET_OPCODE) && (inst_q[14:12] == VSET_FUNCT3);
    assign is_vsetvli  = !inst_q[31];
    assign is_vsetivli = (inst_q[31:30] == 2'b11);
    assign is_vsetvl   = (inst_q[31:25] == VSETVL_FUNCT7);
    assign dec_illegal = !is_vset || !(is_vsetvli || is_vsetivli || is_vsetvl);

    always_comb begin
        vtype_raw = rs2_q;
        if (is_vsetvli)
            vtype_raw = XLEN'(inst_q[30:20]);
        else if (is_vsetivli)
            vtype_raw = XLEN'(inst_q[29:20]);
    end

    vec_vlmax_calc #(.VLEN(VLEN), .VLMAX_W(VLMAX_W)) u_vlmax_calc (
        .vsew        (vew_e'(vtype_raw[VTYPE_VSEW_LSB +: 3])),
        .vlmul       (vlmul_e'(vtype_raw[VTYPE_VLMUL_LSB +: 3])),
        .vlmax       (vlmax),
        .vtype_legal (vtype_legal)
    );

    assign vill    = !vtype_legal || (|vtype_raw[XLEN-1:VTYPE_FIELD_W]);
    assign vlmax_x = XLEN'(vlmax);

    // rs1=x0 with rd!=x0 requests VLMAX; both x0 keeps the current vl.
    always_comb begin
        avl = cur_vl_q;
        if (is_vsetivli)
            avl = XLEN'(rs1_idx);
        else if (rs1_idx != 5'd0)
            avl = rs1_q;
        else if (rd_idx != 5'd0)
            avl = '1;
    end

    always_comb begin
        vl_calc = (avl < vlmax_x) ? avl : vlmax_x;
`ifdef VSETVL_AVL_SPLIT_EN
        if ((avl > vlmax_x) && ({1'b0, avl} < {vlmax_x, 1'b0}))
            vl_calc = (avl >> 1) + XLEN'(avl[0]);
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            inst_q   <= inst;
            rs1_q    <= rs1_data;
            rs2_q    <= rs2_data;
            cur_vl_q <= cur_vl;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            csrwr_en  <= 1'b0;
            rd_valid  <= 1'b0;
            illegal   <= 1'b0;
            rd_data   <= '0;
            vl_out    <= '0;
            vtype_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= CALC;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CALC: begin
                    state   <= COMMIT;
                    illegal <= dec_illegal;
                    rd_data <= (dec_illegal || vill) ? '0 : vl_calc;
                    if (!dec_illegal) begin
                        csrwr_en  <= 1'b1;
                        vl_out    <= vill ? '0 : vl_calc;
                        vtype_out <= vill ? {1'b1, {(XLEN-1){1'b0}}}
                                          : {{(XLEN-VTYPE_FIELD_W){1'b0}}, vtype_raw[VTYPE_FIELD_W-1:0]};
                    end
                end
                COMMIT: begin
                    state    <= RESP;
                    csrwr_en <= 1'b0;
                    rd_valid <= 1'b1;
                end
                RESP: begin
                    if (rd_ready) begin
                        state     <= IDLE;
                        rd_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Self-checking bench for vec_vsetvl_unit: directed cases plus random vset traffic
// checked against a behavioural model.
module tb_vec_vsetvl_unit;

    localparam int XLEN = 32;
    localparam int VLEN = 512;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [XLEN-1:0] inst, rs1_data, rs2_data, cur_vl;
    logic            req_valid, req_ready;
    logic [XLEN-1:0] vl_out, vtype_out, rd_data;
    logic            csrwr_en, rd_valid, rd_ready, illegal, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_vl_reg, exp_vtype_reg;

    vec_vsetvl_unit #(.XLEN(XLEN), .VLEN(VLEN)) dut (
        .clk(clk), .n_rst(n_rst), .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .cur_vl(cur_vl), .req_valid(req_valid), .req_ready(req_ready), .vl_out(vl_out),
        .vtype_out(vtype_out), .csrwr_en(csrwr_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_vli(input logic [10:0] zimm, input logic [4:0] rs1, input logic [4:0] rd);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vili(input logic [9:0] zimm, input logic [4:0] uimm, input logic [4:0] rd);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vl(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    // Behavioural reference: plain integer arithmetic on the instruction fields.
    function automatic void model(input logic [31:0] in, input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] cvl, output bit ill, output bit wr,
                                  output logic [31:0] vl, output logic [31:0] vtype, output logic [31:0] rd);
        longint unsigned vt, avl, vlmax, res;
        int kind, sew, lmul;
        ill = 0; wr = 0; vl = 0; vtype = 0; rd = 0;
        if (in[6:0] != 7'h57 || in[14:12] != 3'b111) begin ill = 1; return; end
        if (in[31] == 1'b0) begin kind = 0; vt = in[30:20]; end
        else if (in[31:30] == 2'b11) begin kind = 1; vt = in[29:20]; end
        else if (in[31:25] == 7'b1000000) begin kind = 2; vt = r2; end
        else begin ill = 1; return; end
        wr = 1;
        lmul = int'(vt % 8);
        sew  = int'((vt / 8) % 8);
        if (lmul > 3 || sew > 3 || vt >= 256) begin vtype = 32'h8000_0000; return; end
        vlmax = (VLEN / (8 * (1 << sew))) * (1 << lmul);
        if (kind == 1) avl = in[19:15];
        else if (in[19:15] != 0) avl = r1;
        else if (in[11:7] != 0) avl = 64'hFFFF_FFFF;
        else avl = cvl;
        res = (avl < vlmax) ? avl : vlmax;
`ifdef VSETVL_AVL_SPLIT_EN
        if (avl > vlmax && avl < 2 * vlmax) res = (avl + 1) / 2;
`endif
        vl = 32'(res); rd = 32'(res); vtype = 32'(vt);
    endfunction

    task automatic run_txn(input logic [31:0] in, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] cvl, input int hold);
        bit e_ill, e_wr;
        logic [31:0] e_vl, e_vtype, e_rd;
        model(in, r1, r2, cvl, e_ill, e_wr, e_vl, e_vtype, e_rd);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        inst = in; rs1_data = r1; rs2_data = r2; cur_vl = cvl; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        inst = $urandom; rs1_data = $urandom; rs2_data = $urandom; cur_vl = $urandom;
        check("calc_csrwr", {31'b0, csrwr_en}, 32'd0);
        check("calc_busy", {31'b0, busy}, 32'd1);
        check("calc_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("commit_csrwr", {31'b0, csrwr_en}, {31'b0, e_wr});
        if (e_wr) begin exp_vl_reg = e_vl; exp_vtype_reg = e_vtype; end
        check("commit_vl_out", vl_out, exp_vl_reg);
        check("commit_vtype_out", vtype_out, exp_vtype_reg);
        check("commit_rd_valid", {31'b0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        check("resp_csrwr", {31'b0, csrwr_en}, 32'd0);
        check("resp_rd_valid", {31'b0, rd_valid}, 32'd1);
        check("resp_rd_data", rd_data, e_rd);
        check("resp_illegal", {31'b0, illegal}, {31'b0, e_ill});
        check("resp_vl_out_stable", vl_out, exp_vl_reg);
        check("resp_vtype_out_stable", vtype_out, exp_vtype_reg);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_rd_valid", {31'b0, rd_valid}, 32'd1);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            check("hold_csrwr", {31'b0, csrwr_en}, 32'd0);
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        check("done_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("done_req_ready", {31'b0, req_ready}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd0);
    endtask

    // Directed case: pins the model against a hand-computed result, then runs it.
    task automatic directed(input string name, input logic [31:0] in, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] cvl, input logic [31:0] lit_vl,
                            input logic [31:0] lit_vtype, input bit lit_ill, input int hold);
        bit m_ill, m_wr;
        logic [31:0] m_vl, m_vtype, m_rd;
        model(in, r1, r2, cvl, m_ill, m_wr, m_vl, m_vtype, m_rd);
        check({name, "_model_vl"}, m_vl, lit_vl);
        check({name, "_model_vtype"}, m_vtype, lit_vtype);
        check({name, "_model_illegal"}, {31'b0, m_ill}, {31'b0, lit_ill});
        run_txn(in, r1, r2, cvl, hold);
    endtask

    initial begin
        logic [31:0] lit20;
        logic [31:0] rin, rr1, rr2;
        logic [10:0] zimm;
        logic [4:0]  ri1, rrd;
        n_rst = 1'b0; req_valid = 1'b0; rd_ready = 1'b0;
        inst = '0; rs1_data = '0; rs2_data = '0; cur_vl = '0;
        exp_vl_reg = '0; exp_vtype_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_csrwr", {31'b0, csrwr_en}, 32'd0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_vl_out", vl_out, 32'd0);
        check("rst_vtype_out", vtype_out, 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

`ifdef VSETVL_AVL_SPLIT_EN
        lit20 = 32'd10;
`else
        lit20 = 32'd16;
`endif
        directed("e32m1_avl100", enc_vli(11'h010, 5'd2, 5'd1), 32'd100, 32'd0, 32'd0, 32'd16, 32'h10, 1'b0, 0);
        directed("e32m1_avl20", enc_vli(11'h010, 5'd2, 5'd1), 32'd20, 32'd0, 32'd0, lit20, 32'h10, 1'b0, 0);
        directed("vsetivli_uimm5", enc_vili(10'h003, 5'd5, 5'd3), 32'd999, 32'd0, 32'd0, 32'd5, 32'h3, 1'b0, 1);
        directed("vsetvl_rsvd_lmul", enc_vl(5'd4, 5'd2, 5'd1), 32'd50, 32'h04, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 0);
        directed("vsetvl_high_bits", enc_vl(5'd4, 5'd2, 5'd1), 32'd50, 32'h100, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 0);
        directed("rs1_x0_rd_x5", enc_vli(11'h019, 5'd0, 5'd5), 32'd3, 32'd0, 32'd0, 32'd16, 32'h19, 1'b0, 0);
        directed("rs1_x0_rd_x0", enc_vli(11'h010, 5'd0, 5'd0), 32'd3, 32'd0, 32'd40, 32'd16, 32'h10, 1'b0, 0);
        directed("avl_zero", enc_vli(11'h0C0, 5'd7, 5'd1), 32'd0, 32'd0, 32'd0, 32'd0, 32'hC0, 1'b0, 0);
        directed("bad_opcode", 32'h0020_80B3, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 0);
        directed("bad_funct7", {7'b1000001, 5'd3, 5'd2, 3'b111, 5'd1, 7'h57}, 32'd7, 32'd8, 32'd0,
                 32'd0, 32'd0, 1'b1, 0);
        directed("rd_ready_stall", enc_vli(11'h008, 5'd2, 5'd1), 32'd30, 32'd0, 32'd0, 32'd30, 32'h8, 1'b0, 5);

        // Reset while the request sits in CALC: no write, no response.
        inst = enc_vli(11'h010, 5'd2, 5'd1); rs1_data = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        exp_vl_reg = '0; exp_vtype_reg = '0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_csrwr", {31'b0, csrwr_en}, 32'd0);
        check("midrst_vl_out", vl_out, 32'd0);
        check("midrst_vtype_out", vtype_out, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_csrwr", {31'b0, csrwr_en}, 32'd0);
            check("midrst_no_rd_valid", {31'b0, rd_valid}, 32'd0);
        end

        for (int n = 0; n < 200; n++) begin
            zimm = {$urandom_range(0, 7) == 0 ? 3'($urandom) : 3'd0, 2'($urandom), 3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 9) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 3))};
            ri1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rr1 = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 1100);
            rr2 = {($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'd0, zimm[7:0]};
            case ($urandom_range(0, 5))
                0, 1: rin = enc_vli(zimm, ri1, rrd);
                2:    rin = enc_vili(zimm[9:0], 5'($urandom), rrd);
                3:    rin = enc_vl(5'($urandom), ri1, rrd);
                4:    rin = {7'($urandom_range(64, 95)), 5'($urandom), ri1, 3'b111, rrd, 7'h57};
                default: rin = $urandom;
            endcase
            run_txn(rin, rr1, rr2, $urandom_range(0, 600), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
